// File: rtl/booth_enc_seq.sv
// Sequential radix-4 Booth recoder: one {single,double,neg} digit per beat plus x/~x/2x/~2x operand vectors.
// Latency: first digit one cycle after operand accept; one beat per cycle; one idle bubble between operations.
// Backpressure: out_ready low freezes every output; in_ready is low for the whole operation.
module booth_enc_seq #(
    parameter int WIDTH     = 16,
    parameter bit SKIP_ZERO = 1'b0,
    localparam int NDIG     = WIDTH / 2,
    localparam int IW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             single,
    output logic             double,
    output logic             neg,
    output logic [IW-1:0]    digit_idx,
    output logic             last,
    output logic [WIDTH:0]   pp_in,
    output logic [WIDTH:0]   pp_in_n,
    output logic [WIDTH:0]   pp_in_2,
    output logic [WIDTH:0]   pp_in_2n
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  x_q, y_q;
    logic [IW-1:0]     idx_q;
    logic              armed_q;
    logic [WIDTH:0]    y_ext;
    logic [2:0]        trip;
    logic [NDIG-1:0]   nz_cur;
    logic              last_c;
    logic              acc_in, acc_out;

    // Digit i is nonzero unless its triple is 000 or 111.
    function automatic logic [NDIG-1:0] nz_mask(input logic [WIDTH-1:0] y);
        logic [WIDTH:0] ye;
        logic [2:0]     t;
        ye      = {y, 1'b0};
        nz_mask = '0;
        for (int i = 0; i < NDIG; i++) begin
            t          = ye[2*i +: 3];
            nz_mask[i] = (t != 3'b000) && (t != 3'b111);
        end
    endfunction

    // Lowest set position at or above start; 0 when there is none.
    function automatic logic [IW-1:0] lowest_from(input logic [NDIG-1:0] m, input int start);
        lowest_from = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (m[i] && (i >= start)) lowest_from = i[IW-1:0];
        end
    endfunction

    assign y_ext  = {y_q, 1'b0};
    assign trip   = y_ext[2*idx_q +: 3];
    assign nz_cur = nz_mask(y_q);

    always_comb begin
        if (SKIP_ZERO) last_c = ((nz_cur >> idx_q) >> 1) == '0;
        else           last_c = (idx_q == IW'(NDIG - 1));
    end

    assign acc_in  = in_valid & in_ready;
    assign acc_out = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_in) state_nxt = RUN;
            RUN:     if (acc_out && last_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated to zero outside RUN so the complemented vectors also read 0 when idle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        single    = 1'b0;
        double    = 1'b0;
        neg       = 1'b0;
        last      = 1'b0;
        digit_idx = '0;
        pp_in     = '0;
        pp_in_n   = '0;
        pp_in_2   = '0;
        pp_in_2n  = '0;
        case (state)
            IDLE: in_ready = armed_q;
            RUN: begin
                out_valid = 1'b1;
                single    = trip[1] ^ trip[0];
                double    = (trip == 3'b011) || (trip == 3'b100);
                neg       = trip[2] & ~(trip[1] & trip[0]);
                last      = last_c;
                digit_idx = idx_q;
                pp_in     = {x_q[WIDTH-1], x_q};
                pp_in_n   = ~{x_q[WIDTH-1], x_q};
                pp_in_2   = {x_q, 1'b0};
                pp_in_2n  = ~{x_q, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            if (acc_in) begin
                x_q   <= multiplicand;
                y_q   <= multiplier;
                idx_q <= SKIP_ZERO ? lowest_from(nz_mask(multiplier), 0) : '0;
            end else if (acc_out && !last_c) begin
                idx_q <= SKIP_ZERO ? lowest_from(nz_cur, int'(idx_q) + 1) : idx_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_booth_enc_seq.sv
// Bench for booth_enc_seq: SKIP_ZERO=0 and SKIP_ZERO=1 instances side by side, checked against a digit-value model.
module tb_booth_enc_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        iv, ordy;
    logic [1:0][W-1:0] mc, ml;
    wire  [1:0]        ir, ov, sg, db, ng, lt;
    wire  [1:0][2:0]   ix;
    wire  [1:0][W:0]   p0, p1, p2, p3;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        booth_enc_seq #(.WIDTH(W), .SKIP_ZERO(g == 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .multiplicand(mc[g]), .multiplier(ml[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .single(sg[g]), .double(db[g]), .neg(ng[g]),
            .digit_idx(ix[g]), .last(lt[g]),
            .pp_in(p0[g]), .pp_in_n(p1[g]), .pp_in_2(p2[g]), .pp_in_2n(p3[g])
        );
    end

    typedef struct {
        int          sel;
        logic [15:0] x, y;
        int          stall_at, stall_n, nbeats;
        logic [16:0] ppi, ppn, pp2, pp2n;
    } vec_t;

    typedef struct packed {
        logic [2:0] idx;
        logic       s, d, n, l;
    } beat_t;

    beat_t exq[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beats from the signed digit value d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1].
    function automatic void build(input int skip, input logic [15:0] y);
        int b2, b1, b0, d;
        exq.delete();
        for (int i = 0; i < 8; i++) begin
            b2 = (2*i+1 <= 15) ? int'(y[2*i+1]) : 0;
            b1 = int'(y[2*i]);
            b0 = (i == 0) ? 0 : int'(y[(2*i+15) % 16]);
            d  = -2*b2 + b1 + b0;
            if (skip == 0 || d != 0)
                exq.push_back('{idx: 3'(i), s: (d == 1 || d == -1), d: (d == 2 || d == -2), n: (d < 0), l: 1'b0});
        end
        if (exq.size() == 0) exq.push_back('{idx: 3'd0, s: 1'b0, d: 1'b0, n: 1'b0, l: 1'b0});
        exq[exq.size()-1].l = 1'b1;
    endfunction

    function automatic vec_t mk(input int sel, input logic [15:0] x, input logic [15:0] y,
                                input int sa, input int sn, input int nb);
        vec_t v;
        int   t;
        v.sel = sel; v.x = x; v.y = y; v.stall_at = sa; v.stall_n = sn; v.nbeats = nb;
        t = int'($signed(x));        v.ppi  = t[16:0];
        t = -int'($signed(x)) - 1;   v.ppn  = t[16:0];
        t = 2 * int'(x);             v.pp2  = t[16:0];
        t = -2 * int'(x) - 1;        v.pp2n = t[16:0];
        return v;
    endfunction

    task automatic check_beat(input int s, input beat_t e, input vec_t v);
        chk("out_valid", ov[s], 1);
        chk("in_ready_run", ir[s], 0);
        chk("digit_idx", ix[s], e.idx);
        chk("single", sg[s], e.s);
        chk("double", db[s], e.d);
        chk("neg", ng[s], e.n);
        chk("last", lt[s], e.l);
        chk("pp_in", p0[s], v.ppi);
        chk("pp_in_n", p1[s], v.ppn);
        chk("pp_in_2", p2[s], v.pp2);
        chk("pp_in_2n", p3[s], v.pp2n);
    endtask

    // Consumes beats starting at a negedge where the first beat should be presented.
    task automatic drain(input vec_t v);
        int s, k, nb;
        logic [31:0] snap0, snap1;
        s = v.sel;
        nb = (v.nbeats < 0) ? exq.size() : v.nbeats;
        k = 0;
        ordy[s] = 1'b1;
        while (ov[s] && k < 12) begin
            if (k < exq.size()) check_beat(s, exq[k], v);
            if (k == v.stall_at) begin
                ordy[s] = 1'b0;
                snap0 = {7'd0, ov[s], ix[s], sg[s], db[s], ng[s], lt[s], p0[s]};
                snap1 = {15'd0, p3[s]};
                repeat (v.stall_n) begin
                    @(negedge clk);
                    chk("hold_ctrl", {7'd0, ov[s], ix[s], sg[s], db[s], ng[s], lt[s], p0[s]}, snap0);
                    chk("hold_pp2n", {15'd0, p3[s]}, snap1);
                end
                ordy[s] = 1'b1;
            end
            k++;
            @(negedge clk);
        end
        chk("beat_count", k, nb);
        chk("out_valid_done", ov[s], 0);
        chk("in_ready_after", ir[s], 1);
    endtask

    task automatic run_op(input vec_t v);
        int s;
        s = v.sel;
        build(s, v.y);
        for (int w = 0; w < 20 && !ir[s]; w++) @(negedge clk);
        chk("in_ready_idle", ir[s], 1);
        mc[s] = v.x; ml[s] = v.y; iv[s] = 1'b1; ordy[s] = 1'b1;
        @(negedge clk);
        iv[s] = 1'b0;
        drain(v);
    endtask

    vec_t tbl[8];
    vec_t v, v2;

    initial begin
        iv = '0; ordy = '0; mc = '0; ml = '0;

        tbl[0] = mk(0, 16'h0003, 16'h0001, -1, 0, 8);
        tbl[0].ppi = 17'h00003; tbl[0].ppn = 17'h1FFFC; tbl[0].pp2 = 17'h00006; tbl[0].pp2n = 17'h1FFF9;
        tbl[1] = mk(0, 16'h8000, 16'hFFFF, -1, 0, 8);
        tbl[1].ppi = 17'h18000; tbl[1].ppn = 17'h07FFF; tbl[1].pp2 = 17'h10000; tbl[1].pp2n = 17'h0FFFF;
        tbl[2] = mk(0, 16'h8000, 16'h8000, -1, 0, 8);
        tbl[3] = mk(0, 16'h1234, 16'h5555, 2, 3, 8);
        tbl[4] = mk(1, 16'h0003, 16'h0101, -1, 0, 2);
        tbl[5] = mk(1, 16'h7FFF, 16'h0000, -1, 0, 1);
        tbl[6] = mk(1, 16'h00FF, 16'h5555, 1, 2, 8);
        tbl[7] = mk(1, 16'hA5A5, 16'hFFFF, 0, 2, 1);

        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst_out_valid", ov[s], 0);
            chk("rst_last", lt[s], 0);
            chk("rst_idx", ix[s], 0);
            chk("rst_pp_in_n", p1[s], 0);
            chk("rst_pp_in_2n", p3[s], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_post_rst0", ir[0], 1);
        chk("in_ready_post_rst1", ir[1], 1);

        foreach (tbl[i]) run_op(tbl[i]);

        // in_valid held high across an operation; the next pair goes in right after the last beat.
        v  = mk(0, 16'h0011, 16'h0003, -1, 0, -1);
        v2 = mk(0, 16'h0022, 16'hC000, -1, 0, -1);
        build(0, v.y);
        mc[0] = v.x; ml[0] = v.y; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("hv_in_ready", ir[0], 0);
            chk("hv_idx", ix[0], exq[k].idx);
            if (lt[0]) begin
                mc[0] = v2.x; ml[0] = v2.y;
            end
            @(negedge clk);
        end
        chk("hv_bubble_valid", ov[0], 0);
        chk("hv_bubble_ready", ir[0], 1);
        @(negedge clk);
        iv[0] = 1'b0;
        build(0, v2.y);
        drain(v2);

        // Reset in the middle of an operation.
        v = mk(0, 16'h0F0F, 16'h5555, -1, 0, -1);
        build(0, v.y);
        mc[0] = v.x; ml[0] = v.y; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        for (int w = 0; w < 10 && !(ov[0] && ix[0] == 3'd3); w++) @(negedge clk);
        chk("pre_rst_idx", ix[0], 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", ov[0], 0);
        chk("arst_idx", ix[0], 0);
        chk("arst_single", sg[0], 0);
        chk("arst_pp_in", p0[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_beat", ov[0], 0);
        chk("arst_in_ready", ir[0], 1);
        run_op(mk(0, 16'h0F0F, 16'h9A3C, -1, 0, -1));
        run_op(mk(1, 16'hFFFF, 16'h4002, -1, 0, -1));

        for (int n = 0; n < 40; n++) begin
            logic [15:0] rx, ry;
            int sa;
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ry = ry & 16'($urandom) & 16'($urandom);
            sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7));
            run_op(mk(int'($urandom_range(0, 1)), rx, ry, sa, int'($urandom_range(1, 3)), -1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
